// File: rtl/icache_responder_if.sv
// icache_responder_if: fetch-side lookup and memory-refill signals of the instruction cache
//   pc, pc_valid, flush         fetch request and cache invalidate (into the cache)
//   instruction, hit, busy      lookup result and FSM activity (out of the cache)
//   mem_req, mem_addr           refill request and word address (out of the cache)
//   mem_rdata, mem_rvalid       refill return data (into the cache)
interface icache_responder_if;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic [31:0] instruction;
  logic        hit;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  modport master (
    output pc, pc_valid, flush, mem_rdata, mem_rvalid,
    input  instruction, hit, busy, mem_req, mem_addr
  );
  modport slave (
    input  pc, pc_valid, flush, mem_rdata, mem_rvalid,
    output instruction, hit, busy, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped instruction cache with in-order line refill from memory
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    slave side of icache_responder_if (fetch lookup + memory refill)
module icache_responder #(
  parameter int          LINES    = 16,
  parameter int          WORDS    = 4,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst_n,
  icache_responder_if.slave bus
);
  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TW = 30 - OB - IB;
  typedef enum logic [1:0] {IDLE, REFILL, COMMIT} state_t;
  state_t state, state_n;
  logic [OB-1:0]    off, cnt;
  logic [IB-1:0]    idx, line_idx;
  logic [TW-1:0]    tag, line_tag;
  logic [IB+TW-1:0] line_base;
  logic [LINES-1:0] valid;
  logic [TW-1:0]    tags [LINES];
  logic [31:0]      data [LINES*WORDS];
  logic             unused_ok;
  assign off       = bus.pc[OB+1:2];
  assign idx       = bus.pc[OB+IB+1:OB+2];
  assign tag       = bus.pc[31:OB+IB+2];
  assign line_idx  = line_base[IB-1:0];
  assign line_tag  = line_base[IB+TW-1:IB];
  assign unused_ok = ^bus.pc[1:0];
  assign bus.hit         = bus.pc_valid & (state == IDLE) & valid[idx] & (tags[idx] == tag) & ~bus.flush;
  assign bus.instruction = bus.hit ? data[{idx, off}] : NOP_WORD;
  assign bus.mem_req     = state == REFILL;
  assign bus.mem_addr    = {line_base, cnt, 2'b00};
  assign bus.busy        = state != IDLE;
  // flush has priority in every state: it aborts a refill and cancels a pending commit
  always_comb begin
    state_n = state;
    if (bus.flush) state_n = IDLE;
    else if (state == IDLE && bus.pc_valid && !bus.hit) state_n = REFILL;
    else if (state == REFILL && bus.mem_rvalid && &cnt) state_n = COMMIT;
    else if (state == COMMIT) state_n = IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (!rst_n) begin
      valid     <= '0;
      cnt       <= '0;
      line_base <= '0;
    end else begin
      if (state == IDLE && state_n == REFILL) begin
        line_base <= bus.pc[31:OB+2];
        cnt       <= '0;
      end
      if (state == REFILL && bus.mem_rvalid && !bus.flush) cnt <= cnt + 1'b1;
      if (state == COMMIT) valid[line_idx] <= 1'b1;
      if (bus.flush) valid <= '0;
    end
  // array contents need no reset: a line is only visible once its valid bit is set
  always_ff @(posedge clk) begin
    if (state == REFILL && bus.mem_rvalid) data[{line_idx, cnt}] <= bus.mem_rdata;
    if (state == COMMIT) tags[line_idx] <= line_tag;
  end
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: self-checking bench for icache_responder
module tb_icache_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  icache_responder_if bus();
  icache_responder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0;
  int passed = 0;
  logic [31:0] exp_q[$];
  typedef struct {
    logic [31:0] pc;
    logic        pv;
    logic        eh;
  } vec_t;
  vec_t tbl[11];
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a * 32'd7 + 32'h1234_5678;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask
  task automatic probe(input logic [31:0] p, input logic pv, input logic eh);
    @(negedge clk);
    bus.pc = p;
    bus.pc_valid = pv;
    #1;
    chk1("probe_hit", bus.hit, eh);
    chk("probe_instr", bus.instruction, eh ? mem_val(p & ~32'h3) : 32'h0);
    #1 bus.pc_valid = 1'b0;
  endtask
  task automatic refill(input logic [31:0] p, input int gap);
    int cyc;
    logic [31:0] base;
    base = p & ~32'hF;
    bus.pc = p;
    bus.pc_valid = 1'b1;
    bus.flush = 1'b0;
    bus.mem_rvalid = 1'b0;
    #1;
    chk1("miss_hit", bus.hit, 1'b0);
    chk("miss_instr", bus.instruction, 32'h0);
    for (int i = 0; i < 4; i++) exp_q.push_back(base + 32'(4 * i));
    @(negedge clk);
    cyc = 1;
    bus.pc = ~p;
    for (int i = 0; i < 4; i++) begin
      if (i > 0)
        for (int g = 0; g < gap; g++) begin
          bus.mem_rvalid = 1'b0;
          #1;
          chk("gap_addr", bus.mem_addr, exp_q[0]);
          chk1("gap_req", bus.mem_req, 1'b1);
          chk1("gap_busy", bus.busy, 1'b1);
          chk1("gap_hit", bus.hit, 1'b0);
          @(negedge clk);
          cyc++;
        end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = mem_val(exp_q[0]);
      #1;
      chk("rv_addr", bus.mem_addr, exp_q.pop_front());
      chk1("rv_req", bus.mem_req, 1'b1);
      @(negedge clk);
      cyc++;
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 32'hDEAD_BEEF;
    bus.pc = p;
    #1;
    chk1("commit_req", bus.mem_req, 1'b0);
    chk1("commit_busy", bus.busy, 1'b1);
    chk1("commit_hit", bus.hit, 1'b0);
    @(negedge clk);
    cyc++;
    #1;
    chk1("refill_hit", bus.hit, 1'b1);
    chk("refill_instr", bus.instruction, mem_val(p & ~32'h3));
    chk("penalty", 32'(cyc), 32'(6 + 3 * gap));
    #1 bus.pc_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    bus.pc = 32'h40;
    bus.pc_valid = 1'b1;
    bus.flush = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_hit", bus.hit, 1'b0);
    chk("rst_instr", bus.instruction, 32'h0);
    chk1("rst_req", bus.mem_req, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    bus.pc_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    refill(32'h40, 0);
    probe(32'h48, 1'b1, 1'b1);
    refill(32'h88, 3);
    refill(32'h0C, 1);
    tbl[0]  = '{32'h40, 1'b1, 1'b1};
    tbl[1]  = '{32'h44, 1'b1, 1'b1};
    tbl[2]  = '{32'h4E, 1'b1, 1'b1};
    tbl[3]  = '{32'h80, 1'b1, 1'b1};
    tbl[4]  = '{32'h8C, 1'b1, 1'b1};
    tbl[5]  = '{32'h00, 1'b1, 1'b1};
    tbl[6]  = '{32'h08, 1'b1, 1'b1};
    tbl[7]  = '{32'h140, 1'b1, 1'b0};
    tbl[8]  = '{32'h10, 1'b1, 1'b0};
    tbl[9]  = '{32'h40, 1'b0, 1'b0};
    tbl[10] = '{32'h1000_0080, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) probe(tbl[i].pc, tbl[i].pv, tbl[i].eh);
    refill(32'h144, 0);
    probe(32'h40, 1'b1, 1'b0);
    probe(32'h80, 1'b1, 1'b1);
    @(negedge clk);
    bus.flush = 1'b1;
    bus.pc = 32'h80;
    bus.pc_valid = 1'b1;
    #1;
    chk1("flush_idle_hit", bus.hit, 1'b0);
    #1 bus.pc_valid = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    probe(32'h144, 1'b1, 1'b0);
    probe(32'h00, 1'b1, 1'b0);
    refill(32'h80, 0);
    @(negedge clk);
    bus.pc = 32'h40;
    bus.pc_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = mem_val(32'h40 + 32'(4 * i));
      #1;
      chk("abort_addr", bus.mem_addr, 32'h40 + 32'(4 * i));
      @(negedge clk);
    end
    bus.mem_rvalid = 1'b0;
    bus.flush = 1'b1;
    #1;
    chk1("abort_req_pre", bus.mem_req, 1'b1);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.pc_valid = 1'b0;
    #1;
    chk1("abort_req", bus.mem_req, 1'b0);
    chk1("abort_busy", bus.busy, 1'b0);
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    #1;
    chk1("stray_busy", bus.busy, 1'b0);
    chk1("stray_req", bus.mem_req, 1'b0);
    refill(32'h40, 2);
    @(negedge clk);
    bus.pc = 32'h300;
    bus.pc_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = mem_val(32'h300 + 32'(4 * i));
      @(negedge clk);
    end
    bus.mem_rvalid = 1'b0;
    bus.flush = 1'b1;
    #1;
    chk1("cflush_busy", bus.busy, 1'b1);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk1("cflush_hit", bus.hit, 1'b0);
    chk1("cflush_idle", bus.busy, 1'b0);
    #1 bus.pc_valid = 1'b0;
    probe(32'h40, 1'b1, 1'b0);
    refill(32'h40, 0);
    @(negedge clk);
    bus.pc = 32'h200;
    bus.pc_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = mem_val(32'h200 + 32'(4 * i));
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk1("mrst_req", bus.mem_req, 1'b0);
    chk1("mrst_busy", bus.busy, 1'b0);
    chk1("mrst_hit", bus.hit, 1'b0);
    chk("mrst_addr", bus.mem_addr, 32'h0);
    bus.pc = 32'h40;
    #1;
    chk1("mrst_old_hit", bus.hit, 1'b0);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.pc_valid = 1'b0;
    rst_n = 1'b1;
    probe(32'h200, 1'b1, 1'b0);
    probe(32'h40, 1'b1, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
